// File: rtl/morse_key_timer.sv
`default_nettype none
// ============================================================================
// Module   : morse_key_timer
// Brief    : Synchronises and debounces a telegraph key, classifies presses as
//            dot/dash and strobes symbol and letter-end events downstream.
// Revision : 1.0 - initial release
// ============================================================================
module morse_key_timer #(
    parameter int DEBOUNCE   = 4,
    parameter int DOT_MAX    = 8,
    parameter int GAP_LETTER = 24,
    parameter int CW         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic       sym,
    output logic       sym_valid,
    output logic       letter_end,
    output logic [2:0] letter_len,
    output logic       letter_err
);

    localparam int            DBW          = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [DBW-1:0] C_DB_LAST   = DBW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]  C_DOT_MAX   = CW'(DOT_MAX);
    localparam logic [CW-1:0]  C_GAP_LETTER = CW'(GAP_LETTER);
    localparam logic [CW-1:0]  C_CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic           r_sync1;
    logic           r_key_s;
    logic           r_key_d;
    logic [DBW-1:0] r_db_cnt;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [2:0]     r_len;
    logic [2:0]     w_len_nxt;
    logic [2:0]     w_len_inc;
    logic [CW-1:0]  w_cnt_inc;

    logic           w_sym_nxt;
    logic           w_sym_valid_nxt;
    logic           w_letter_end_nxt;
    logic [2:0]     w_letter_len_nxt;
    logic           w_letter_err_nxt;

    // Input conditioning: two-flop synchroniser followed by a run-length debounce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_key_s  <= 1'b0;
            r_key_d  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= key;
            r_key_s <= r_sync1;
            if (r_key_s == r_key_d) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == C_DB_LAST) begin
                r_key_d  <= r_key_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
        end
    end

    assign w_len_inc = (r_len == 3'd7) ? 3'd7 : r_len + 3'd1;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + C_CNT_ONE;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_len_nxt        = r_len;
        w_sym_nxt        = sym;
        w_sym_valid_nxt  = 1'b0;
        w_letter_end_nxt = 1'b0;
        w_letter_len_nxt = letter_len;
        w_letter_err_nxt = letter_err;

        case (r_state)
            IDLE: begin
                if (r_key_d) begin
                    w_state_nxt = PRESS;
                    w_cnt_nxt   = C_CNT_ONE;
                    w_len_nxt   = 3'd0;
                end
            end
            PRESS: begin
                if (r_key_d) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_sym_nxt       = (r_cnt <= C_DOT_MAX);
                    w_sym_valid_nxt = 1'b1;
                    w_len_nxt       = w_len_inc;
                    w_state_nxt     = GAP;
                    w_cnt_nxt       = C_CNT_ONE;
                end
            end
            GAP: begin
                // A new press wins over a letter end landing on the same cycle.
                if (r_key_d) begin
                    w_state_nxt = PRESS;
                    w_cnt_nxt   = C_CNT_ONE;
                end else if (r_cnt == C_GAP_LETTER) begin
                    w_letter_end_nxt = 1'b1;
                    w_letter_len_nxt = r_len;
                    w_letter_err_nxt = (r_len > 3'd5);
                    w_state_nxt      = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= 3'd0;
            sym        <= 1'b0;
            sym_valid  <= 1'b0;
            letter_end <= 1'b0;
            letter_len <= 3'd0;
            letter_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            sym        <= w_sym_nxt;
            sym_valid  <= w_sym_valid_nxt;
            letter_end <= w_letter_end_nxt;
            letter_len <= w_letter_len_nxt;
            letter_err <= w_letter_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_key_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_key_timer
// Brief    : Self-checking bench for morse_key_timer (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_key_timer;

    localparam int C_DEB = 2;
    localparam int C_DOT = 3;
    localparam int C_GAP = 6;
    // Key release driven at cycle r -> first low sample on the FSM at r+3+DEBOUNCE.
    localparam int C_SYM_LAT = 3 + C_DEB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key = 1'b0;
    logic       sym;
    logic       sym_valid;
    logic       letter_end;
    logic [2:0] letter_len;
    logic       letter_err;

    morse_key_timer #(
        .DEBOUNCE  (C_DEB),
        .DOT_MAX   (C_DOT),
        .GAP_LETTER(C_GAP),
        .CW        (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .sym       (sym),
        .sym_valid (sym_valid),
        .letter_end(letter_end),
        .letter_len(letter_len),
        .letter_err(letter_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         press;
        int         gap;
        bit         exp_sym;
        bit         exp_le;
        logic [2:0] exp_len;
        bit         exp_err;
    } vec_t;

    typedef struct {
        bit         is_letter;
        bit         val;
        logic [2:0] len;
        bit         err;
        int         cyc;
    } ev_t;

    vec_t vecs[$];
    ev_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   watch_glitch = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void add(input int p, input int g, input bit s, input bit le,
                                input logic [2:0] len, input bit err);
        vec_t v;
        v.press = p; v.gap = g; v.exp_sym = s; v.exp_le = le; v.exp_len = len; v.exp_err = err;
        vecs.push_back(v);
    endfunction

    // Monitor: samples on the falling edge, pops the scoreboard on every strobe.
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            chk("rst_sym", {31'd0, sym}, 0);
            chk("rst_sym_valid", {31'd0, sym_valid}, 0);
            chk("rst_letter_end", {31'd0, letter_end}, 0);
            chk("rst_letter_len", {29'd0, letter_len}, 0);
            chk("rst_letter_err", {31'd0, letter_err}, 0);
        end else begin
            if (sym_valid && letter_end)
                chk("strobe_overlap", 1, 0);
            if (sym_valid || letter_end) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", {31'd0, letter_end}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind", {31'd0, letter_end}, {31'd0, e.is_letter});
                    chk("strobe_cycle", cyc, e.cyc);
                    if (e.is_letter) begin
                        chk("letter_len", {29'd0, letter_len}, {29'd0, e.len});
                        chk("letter_err", {31'd0, letter_err}, {31'd0, e.err});
                    end else begin
                        chk("sym", {31'd0, sym}, {31'd0, e.val});
                    end
                end
            end
        end
        if (watch_glitch)
            chk("glitch_key_d", {31'd0, dut.r_key_d}, 0);
    end

    // Drives key = v from now for n sampling edges; returns at posedge+2.
    task automatic hold(input logic v, input int n);
        key = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_sym(input int r, input bit s);
        ev_t e;
        e.is_letter = 1'b0; e.val = s; e.len = 3'd0; e.err = 1'b0; e.cyc = r + C_SYM_LAT;
        sb.push_back(e);
    endtask

    task automatic push_letter(input int r, input logic [2:0] len, input bit err);
        ev_t e;
        e.is_letter = 1'b1; e.val = 1'b0; e.len = len; e.err = err; e.cyc = r + C_SYM_LAT + C_GAP;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #2;
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int r;

        // Single presses across the dot/dash boundary.
        add(3, 12, 1'b1, 1'b1, 3'd1, 1'b0);
        add(4, 12, 1'b0, 1'b1, 3'd1, 1'b0);
        add(40, 12, 1'b0, 1'b1, 3'd1, 1'b0);
        add(1 + 1, 12, 1'b1, 1'b1, 3'd1, 1'b0);
        // Letter "A".
        add(2, 2, 1'b1, 1'b0, 3'd0, 1'b0);
        add(5, 12, 1'b0, 1'b1, 3'd2, 1'b0);
        // Short gap below the letter threshold must not end the letter.
        add(2, 5, 1'b1, 1'b0, 3'd0, 1'b0);
        add(2, 12, 1'b1, 1'b1, 3'd2, 1'b0);
        // Six dots: overlong letter.
        for (int i = 0; i < 5; i++) add(2, 2, 1'b1, 1'b0, 3'd0, 1'b0);
        add(2, 12, 1'b1, 1'b1, 3'd6, 1'b1);
        // Eight symbols: length saturates at 7.
        for (int i = 0; i < 7; i++) add(i[0] ? 5 : 2, 3, ~i[0], 1'b0, 3'd0, 1'b0);
        add(6, 12, 1'b0, 1'b1, 3'd7, 1'b1);
        // Letter "N" after the error letter clears the error flag.
        add(6, 2, 1'b0, 1'b0, 3'd0, 1'b0);
        add(3, 12, 1'b1, 1'b1, 3'd2, 1'b0);

        // Reset with key toggling: outputs held at zero.
        for (int i = 0; i < 10; i++) begin
            key = ~key;
            @(posedge clk);
        end
        #2;
        reset = 1'b0;
        hold(1'b0, 20);
        drain("idle_after_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            hold(1'b1, vecs[i].press);
            r = cyc;
            push_sym(r, vecs[i].exp_sym);
            if (vecs[i].exp_le) push_letter(r, vecs[i].exp_len, vecs[i].exp_err);
            hold(1'b0, vecs[i].gap);
        end
        drain("table_drain");

        // Glitches: single-cycle key pulses never reach key_d.
        watch_glitch = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 1);
            hold(1'b0, 4 + i);
        end
        hold(1'b0, 6);
        watch_glitch = 1'b0;
        drain("glitch_drain");

        // Overlong letter, then reset in the middle of the next letter's 3rd press.
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 2);
            r = cyc;
            push_sym(r, 1'b1);
            if (i == 5) push_letter(r, 3'd6, 1'b1);
            hold(1'b0, (i == 5) ? 12 : 2);
        end
        drain("six_dot_drain");
        for (int i = 0; i < 2; i++) begin
            hold(1'b1, 2);
            r = cyc;
            push_sym(r, 1'b1);
            hold(1'b0, 2);
        end
        hold(1'b1, 8);
        chk("pre_reset_pending", sb.size(), 0);
        reset = 1'b1;
        #1;
        chk("async_rst_sym", {31'd0, sym}, 0);
        chk("async_rst_key_d", {31'd0, dut.r_key_d}, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        // Key still held through release: behaves as a fresh 3-cycle press.
        reset = 1'b0;
        hold(1'b1, 3);
        r = cyc;
        push_sym(r, 1'b1);
        push_letter(r, 3'd1, 1'b0);
        hold(1'b0, 12);
        drain("post_reset_drain");

        hold(1'b1, 4);
        r = cyc;
        push_sym(r, 1'b0);
        push_letter(r, 3'd1, 1'b0);
        hold(1'b0, 12);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/morse_key_timer.md
# morse_key_timer

- Front-end stage of the Morse receive path.
- Takes the raw, asynchronous telegraph key line, then synchronises and debounces it.
- Classifies each key press by duration as a dot or a dash, and detects the inter-letter gap.
- Emits one-cycle symbol strobes (dot = 1, dash = 0) and a letter-end strobe. These drive the serial symbol input and per-letter restart of the downstream Morse decoder.

## Interface
- DEBOUNCE, 4: cycles `key_s` must differ from `key_d` before `key_d` toggles (≥1).
- DOT_MAX, 8: a press of ≤ DOT_MAX debounced cycles is a dot; longer is a dash (≥1).
- GAP_LETTER, 24: consecutive debounced-low cycles that end a letter (≥2).
- CW, 16: width of the duration counter; must hold max(DOT_MAX, GAP_LETTER)+1.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- key  input  1  raw key line, 1 = pressed; asynchronous to clk.
- sym  output  1  symbol value, valid when `sym_valid`=1: 1 = dot, 0 = dash.
- sym_valid  output  1  one-cycle strobe per completed press.
- letter_end  output  1  one-cycle strobe when the letter-gap threshold is reached.
- letter_len  output  3  symbols in the finished letter, valid with `letter_end`; saturates at 7.
- letter_err  output  1  valid with `letter_end`: 1 if letter_len > 5 (no legal code).

## Operation

Input conditioning:
- Two-flop synchroniser: key → `key_s`.
- Debounce counter: increments while `key_s` ≠ `key_d`, clears when they are equal.
- When the counter reaches DEBOUNCE, `key_d` ← `key_s` and the counter clears.

State machine (states IDLE, PRESS, GAP; reset → IDLE):
- IDLE
  - `key_d`=1 → PRESS, cnt ← 1, len ← 0.
  - Else stay.
- PRESS
  - `key_d`=1: cnt ← cnt+1, saturating at all-ones.
  - `key_d`=0: emit symbol (sym ← (cnt ≤ DOT_MAX)), len ← sat7(len+1), → GAP, cnt ← 1.
- GAP
  - `key_d`=1 → PRESS, cnt ← 1. A press has priority over letter end on the same cycle.
  - Else if cnt = GAP_LETTER → emit letter_end with letter_len ← len and letter_err ← (len > 5), → IDLE.
  - Else cnt ← cnt+1.

Output rules:
- Outputs are registered and update on the clock edge that performs the transition.
- `sym` and `letter_len`/`letter_err` hold their last value between strobes.
- `sym_valid` and `letter_end` are high for exactly one cycle each. They never assert in the same cycle.
- Press duration = number of consecutive cycles `key_d` was 1. Gap duration = number of consecutive cycles `key_d` was 0, counted from the cycle `key_d` first reads 0.
- Release in IDLE has no effect. A letter is only opened by a press.

## Timing
- Reset (asynchronous assert, any cycle, including mid-press or mid-gap):
  - sym=0, sym_valid=0, letter_end=0, letter_len=0, letter_err=0.
  - `key_d`=0, synchroniser flops 0, counters 0, state IDLE.
  - A partial symbol or letter is discarded with no strobe.
- Key-to-`key_d` latency: 2 (sync) + DEBOUNCE cycles. Pulses on `key_s` shorter than DEBOUNCE cycles are ignored.
- `sym_valid` rises 1 cycle after the first cycle `key_d` reads 0 following a press.
- `letter_end` rises on the edge after the GAP_LETTER-th consecutive low cycle.
- If key is held high through and after reset release, `key_d` rises 2+DEBOUNCE cycles later and a normal press begins.
- Press longer than the counter range saturates and classifies as dash.
- 6th and later symbols in a letter still produce `sym_valid`. letter_len saturates at 7; letter_err=1.

## Test plan
Common parameters: DEBOUNCE=2, DOT_MAX=3, GAP_LETTER=6. All durations are measured on `key_d`.

- Reset values: assert reset with key toggling → every output 0 throughout. After release with key=0 for 20 cycles → no strobes.
- Dot/dash boundary:
  - 3-cycle press → one `sym_valid` with sym=1.
  - 4-cycle press → sym=0.
  - 40-cycle press → sym=0.
- Letter "A": press 2, low 2, press 5, low 6 →
  - `sym_valid` with sym=1, then `sym_valid` with sym=0.
  - Then `letter_end` with letter_len=2, letter_err=0.
  - Exactly 3 strobes total.
- Gap/press race: press 2, low 5, press 2, low 6 → two dots and one `letter_end` with len=2. No letter_end after the 5-cycle gap.
- Glitch rejection: 1-cycle high pulses on key separated by ≥4 low cycles → `key_d` never rises, no strobes.
- Overlong letter and mid-operation reset:
  - Six dots with 2-cycle gaps → 6 `sym_valid`, then `letter_end` with len=6, letter_err=1.
  - Reset asserted during the 3rd press of the next letter → no strobe.
  - After reset, a new press is classified normally.
